// File: rtl/ifu_prefetch.sv
// Instruction prefetch front end: issues sequential fetches, tracks in-flight requests
// across redirects with an epoch bit, and pushes current-epoch responses into a fifo_sc.
module ifu_prefetch #(
  parameter int unsigned             P_ADDR_WIDTH = 32,
  parameter int unsigned             P_DATA_WIDTH = 32,
  parameter int unsigned             P_DEPTH      = 8,
  parameter int unsigned             P_MAX_OUTST  = 2,
  parameter logic [P_ADDR_WIDTH-1:0] P_BOOT_ADDR  = '0
) (
  input  logic                                 i_clk,
  input  logic                                 i_rstn,
  input  logic                                 i_fetch_en,
  input  logic                                 i_flush,
  input  logic [P_ADDR_WIDTH-1:0]              i_flush_pc,
  output logic                                 o_mem_req,
  output logic [P_ADDR_WIDTH-1:0]              o_mem_addr,
  input  logic                                 i_mem_gnt,
  input  logic                                 i_mem_rvalid,
  input  logic [P_DATA_WIDTH-1:0]              i_mem_rdata,
  input  logic                                 i_mem_err,
  output logic                                 o_fifo_wr_en,
  output logic [P_ADDR_WIDTH+P_DATA_WIDTH+1:0] o_fifo_data,
  input  logic                                 i_fifo_rd_en,
  output logic                                 o_epoch,
  output logic                                 o_halted
);

  localparam int unsigned OW = $clog2(P_MAX_OUTST + 1);
  localparam int unsigned CW = $clog2(P_DEPTH + 1);
  localparam int unsigned PW = (P_MAX_OUTST > 1) ? $clog2(P_MAX_OUTST) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_KILL, S_HALT} state_t;

  state_t                                   state_q, state_d;
  logic [P_ADDR_WIDTH-1:0]                  pc_q;
  logic                                     epoch_q;
  logic                                     hold_q;
  logic [OW-1:0]                            outst_q, stale_q;
  logic [CW-1:0]                            occ_q;
  logic [P_MAX_OUTST-1:0][P_ADDR_WIDTH-1:0] tag_q;
  logic [PW-1:0]                            rd_ptr_q, wr_ptr_q;

  logic          req_room, mem_req, grant;
  logic          resp_stale, resp_cur, push, pop, flush_kill;
  logic [OW-1:0] outst_nxt, stale_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == P_MAX_OUTST - 1) ? '0 : p + PW'(1);
  endfunction

  // Stale responses are always older than current ones, so the stale count decides ownership of the head.
  always_comb begin
    req_room   = i_fetch_en && (32'(outst_q) < P_MAX_OUTST)
                 && ((32'(occ_q) + 32'(outst_q)) < P_DEPTH);
    mem_req    = (state_q == S_FETCH) && (hold_q || req_room);
    grant      = mem_req && i_mem_gnt;
    resp_stale = i_mem_rvalid && (stale_q != '0);
    resp_cur   = i_mem_rvalid && (stale_q == '0) && (outst_q != '0);
    push       = resp_cur && (32'(occ_q) < P_DEPTH);
    pop        = i_fifo_rd_en && (occ_q != '0);
    outst_nxt  = outst_q + OW'(grant) - OW'(resp_cur);
    stale_nxt  = stale_q - OW'(resp_stale);
    flush_kill = i_flush && ((stale_nxt + outst_nxt) != '0);
  end

  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = flush_kill ? S_KILL : S_FETCH;
    end else begin
      case (state_q)
        S_IDLE:  if (i_fetch_en) state_d = S_FETCH;
        S_FETCH: begin
          if (resp_cur && i_mem_err) state_d = S_HALT;
          else if (!i_fetch_en && (outst_q == '0) && !hold_q) state_d = S_IDLE;
        end
        S_KILL:  if (stale_nxt == '0) state_d = S_FETCH;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // A flush folds everything still in flight, including this cycle's grant, into the stale count.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pc_q     <= P_BOOT_ADDR;
      epoch_q  <= 1'b0;
      hold_q   <= 1'b0;
      outst_q  <= '0;
      stale_q  <= '0;
      occ_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      hold_q <= mem_req && !i_mem_gnt && !i_flush && (state_d == S_FETCH);
      if (push && !pop)      occ_q <= occ_q + CW'(1);
      else if (pop && !push) occ_q <= occ_q - CW'(1);
      if (grant)                   wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (resp_stale || resp_cur)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (i_flush) begin
        pc_q    <= i_flush_pc & ~P_ADDR_WIDTH'(3);
        epoch_q <= ~epoch_q;
        stale_q <= stale_nxt + outst_nxt;
        outst_q <= '0;
      end else begin
        if (grant) pc_q <= pc_q + P_ADDR_WIDTH'(4);
        stale_q <= stale_nxt;
        outst_q <= outst_nxt;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)    tag_q <= '0;
    else if (grant) tag_q[wr_ptr_q] <= pc_q;
  end

  assign o_mem_req    = mem_req;
  assign o_mem_addr   = pc_q;
  assign o_fifo_wr_en = push;
  assign o_fifo_data  = push ? {epoch_q, i_mem_err, tag_q[rd_ptr_q], i_mem_rdata} : '0;
  assign o_epoch      = epoch_q;
  assign o_halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: directed vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_ifu_prefetch;

  localparam int DEPTH = 8;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0, flush = 1'b0, gnt = 1'b0, rvalid = 1'b0, err = 1'b0, rd_en = 1'b0;
  logic [31:0] flush_pc = '0, rdata = '0;
  logic        mem_req, fifo_wr_en, epoch, halted;
  logic [31:0] mem_addr;
  logic [65:0] fifo_data;

  ifu_prefetch dut (
    .i_clk(clk), .i_rstn(rst_n), .i_fetch_en(fetch_en), .i_flush(flush), .i_flush_pc(flush_pc),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_gnt(gnt), .i_mem_rvalid(rvalid),
    .i_mem_rdata(rdata), .i_mem_err(err), .o_fifo_wr_en(fifo_wr_en), .o_fifo_data(fifo_data),
    .i_fifo_rd_en(rd_en), .o_epoch(epoch), .o_halted(halted)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: in-flight requests carry the flush generation they were issued in.
  typedef struct { logic [31:0] pc; int gen; } tag_t;
  tag_t        mq[$];
  logic [31:0] m_pc;
  int          m_gen, m_occ;
  logic        m_halt, m_run, m_held;

  logic        last_req, last_wr, last_halt, last_grant;
  logic [31:0] last_addr;
  logic [65:0] last_data;

  task automatic model_reset();
    mq.delete();
    m_pc = '0; m_gen = 0; m_occ = 0;
    m_halt = 1'b0; m_run = 1'b0; m_held = 1'b0;
  endtask

  task automatic step();
    int          nst, sz_pre;
    logic        e_req, e_wr, cur, dec, halt_pre, held_pre;
    logic [65:0] e_data;
    logic [31:0] gen_lsb;
    #1;
    nst = 0;
    foreach (mq[i]) if (mq[i].gen != m_gen) nst++;
    e_req = m_run && !m_halt && (nst == 0)
            && (m_held || (fetch_en && (mq.size() < MAXO) && (m_occ + mq.size() < DEPTH)));
    cur = 1'b0;
    if (rvalid && mq.size() > 0) cur = (mq[0].gen == m_gen);
    e_wr = cur && (m_occ < DEPTH);
    gen_lsb = 32'(m_gen);
    e_data = '0;
    if (e_wr) e_data = {gen_lsb[0], err, mq[0].pc, rdata};

    chk("req", mem_req, e_req);
    if (e_req) chk("addr", mem_addr, m_pc);
    chk("wr_en", fifo_wr_en, e_wr);
    if (e_wr) chk("data", fifo_data, e_data);
    chk("epoch", epoch, gen_lsb[0]);
    chk("halted", halted, m_halt);
    last_req = mem_req; last_addr = mem_addr; last_wr = fifo_wr_en;
    last_data = fifo_data; last_halt = halted; last_grant = mem_req && gnt;

    halt_pre = m_halt; held_pre = m_held; sz_pre = mq.size();
    dec = rd_en && (m_occ > 0);
    if (rvalid && mq.size() > 0) void'(mq.pop_front());
    m_occ = m_occ + (e_wr ? 1 : 0) - (dec ? 1 : 0);
    if (e_req && gnt) begin
      mq.push_back('{pc: m_pc, gen: m_gen});
      m_pc = m_pc + 32'd4;
    end
    if (flush) begin
      m_gen++;
      m_pc = flush_pc & ~32'd3;
      m_halt = 1'b0; m_run = 1'b1; m_held = 1'b0;
    end else begin
      if (cur && err) m_halt = 1'b1;
      m_held = e_req && !gnt && !(cur && err);
      if (!m_run) m_run = fetch_en;
      else if (!halt_pre && !fetch_en && sz_pre == 0 && !held_pre) m_run = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    fetch_en = 1'b0; flush = 1'b0; gnt = 1'b0; rvalid = 1'b0; err = 1'b0; rd_en = 1'b0;
    flush_pc = '0; rdata = '0;
  endtask

  // Asserts reset from a negedge, checks outputs inside the reset window, releases on a later negedge.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wr", fifo_wr_en, 1'b0);
    chk("rst_data", fifo_data, 66'h0);
    chk("rst_epoch", epoch, 1'b0);
    chk("rst_halted", halted, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic fe, g, rv; logic [31:0] rd_dat; logic er, fl; logic [31:0] fpc; logic rd;
    logic e_req; logic [31:0] e_addr; logic e_wr; logic [65:0] e_data; logic e_ep;
  } vec_t;

  function automatic vec_t mk(input logic fe, g, rv, input logic [31:0] rd_dat, input logic fl,
                              input logic [31:0] fpc, input logic rd, input logic e_req,
                              input logic [31:0] e_addr, input logic e_wr,
                              input logic [65:0] e_data, input logic e_ep);
    vec_t v;
    v.fe = fe; v.g = g; v.rv = rv; v.rd_dat = rd_dat; v.er = 1'b0; v.fl = fl; v.fpc = fpc;
    v.rd = rd; v.e_req = e_req; v.e_addr = e_addr; v.e_wr = e_wr; v.e_data = e_data; v.e_ep = e_ep;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    int ng;
    model_reset();
    quiet();
    // Sequential fetch, then redirect to 0x103 with two requests in flight, then a held request.
    tbl[0]  = mk(1,1,0,32'h0,        0,32'h0,  0, 0,32'h0,  0,66'h0,                                 0);
    tbl[1]  = mk(1,1,0,32'h0,        0,32'h0,  0, 1,32'h0,  0,66'h0,                                 0);
    tbl[2]  = mk(1,1,1,32'h1111_0000,0,32'h0,  0, 1,32'h4,  1,{2'b00,32'h0,  32'h1111_0000},         0);
    tbl[3]  = mk(1,1,1,32'h2222_0001,0,32'h0,  1, 1,32'h8,  1,{2'b00,32'h4,  32'h2222_0001},         0);
    tbl[4]  = mk(1,1,1,32'h3333_0002,0,32'h0,  1, 1,32'hC,  1,{2'b00,32'h8,  32'h3333_0002},         0);
    tbl[5]  = mk(1,1,0,32'h0,        0,32'h0,  1, 1,32'h10, 0,66'h0,                                 0);
    tbl[6]  = mk(1,1,0,32'h0,        1,32'h103,1, 0,32'h0,  0,66'h0,                                 0);
    tbl[7]  = mk(1,1,1,32'hDEAD_0007,0,32'h0,  1, 0,32'h0,  0,66'h0,                                 1);
    tbl[8]  = mk(1,1,1,32'hDEAD_0008,0,32'h0,  1, 0,32'h0,  0,66'h0,                                 1);
    tbl[9]  = mk(1,1,0,32'h0,        0,32'h0,  1, 1,32'h100,0,66'h0,                                 1);
    tbl[10] = mk(1,0,1,32'hBBBB_0000,0,32'h0,  1, 1,32'h104,1,{2'b10,32'h100,32'hBBBB_0000},         1);
    tbl[11] = mk(0,0,0,32'h0,        0,32'h0,  1, 1,32'h104,0,66'h0,                                 1);
    tbl[12] = mk(0,1,0,32'h0,        0,32'h0,  1, 1,32'h104,0,66'h0,                                 1);
    tbl[13] = mk(0,0,1,32'hBBBB_0001,0,32'h0,  1, 0,32'h0,  1,{2'b10,32'h104,32'hBBBB_0001},         1);
    tbl[14] = mk(0,0,0,32'h0,        0,32'h0,  1, 0,32'h0,  0,66'h0,                                 1);

    @(negedge clk);
    apply_reset();
    foreach (tbl[i]) begin
      fetch_en = tbl[i].fe; gnt = tbl[i].g; rvalid = tbl[i].rv; rdata = tbl[i].rd_dat;
      err = tbl[i].er; flush = tbl[i].fl; flush_pc = tbl[i].fpc; rd_en = tbl[i].rd;
      #1;
      chk($sformatf("tbl_req[%0d]", i), mem_req, tbl[i].e_req);
      if (tbl[i].e_req) chk($sformatf("tbl_addr[%0d]", i), mem_addr, tbl[i].e_addr);
      chk($sformatf("tbl_wr[%0d]", i), fifo_wr_en, tbl[i].e_wr);
      if (tbl[i].e_wr) chk($sformatf("tbl_data[%0d]", i), fifo_data, tbl[i].e_data);
      chk($sformatf("tbl_epoch[%0d]", i), epoch, tbl[i].e_ep);
      step();
    end

    // Fill the fifo with no pops: exactly P_DEPTH grants, then one pop allows one more.
    quiet();
    apply_reset();
    ng = 0;
    for (int c = 0; c < 40; c++) begin
      fetch_en = 1'b1; gnt = 1'b1; rd_en = 1'b0;
      rvalid = (mq.size() > 0); rdata = $urandom;
      step();
      if (last_grant) ng++;
    end
    chk("fill_grants", 32'(ng), 32'd8);
    chk("fill_req_off", last_req, 1'b0);
    ng = 0;
    for (int c = 0; c < 11; c++) begin
      rd_en = (c == 0); rvalid = (mq.size() > 0); rdata = $urandom;
      step();
      if (last_grant) ng++;
    end
    chk("pop_one_grant", 32'(ng), 32'd1);

    // Grant stall keeps the address stable; 0xFFFF_FFFC wraps to 0.
    quiet();
    apply_reset();
    fetch_en = 1'b1;
    step();
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stall_req", last_req, 1'b1);
      chk("stall_addr", last_addr, 32'h0);
    end
    flush = 1'b1; flush_pc = 32'hFFFF_FFFE;
    step();
    flush = 1'b0; gnt = 1'b1;
    step();
    chk("wrap_pre_addr", last_addr, 32'hFFFF_FFFC);
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h7;
    step();
    chk("wrap_addr", last_addr, 32'h0);
    chk("wrap_data", last_data, {2'b10, 32'hFFFF_FFFC, 32'h7});

    // Error response halts fetching until a flush.
    quiet();
    apply_reset();
    fetch_en = 1'b1; gnt = 1'b1;
    step();
    step();
    gnt = 1'b0; rvalid = 1'b1; err = 1'b1; rdata = 32'hE0E0_E0E0;
    step();
    chk("err_wr", last_wr, 1'b1);
    chk("err_bit", last_data, {2'b01, 32'h0, 32'hE0E0_E0E0});
    rvalid = 1'b0; err = 1'b0; gnt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("halt_flag", last_halt, 1'b1);
      chk("halt_req", last_req, 1'b0);
    end
    flush = 1'b1; flush_pc = 32'h40;
    step();
    flush = 1'b0;
    step();
    chk("unhalt_flag", last_halt, 1'b0);
    chk("unhalt_addr", last_addr, 32'h40);

    // Reset with two requests in flight; a stray response afterwards is ignored.
    quiet();
    apply_reset();
    fetch_en = 1'b1; gnt = 1'b1;
    for (int c = 0; c < 3; c++) step();
    rvalid = 1'b1;
    apply_reset();
    fetch_en = 1'b0; gnt = 1'b0; rvalid = 1'b1;
    step();
    chk("stray_wr", last_wr, 1'b0);
    rvalid = 1'b0; fetch_en = 1'b1;
    step();
    step();
    chk("restart_req", last_req, 1'b1);
    chk("restart_addr", last_addr, 32'h0);

    // Randomized traffic against the model.
    quiet();
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      fetch_en = ($urandom_range(0, 9) != 0);
      gnt      = ($urandom_range(0, 9) < 6);
      rvalid   = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      rdata    = $urandom;
      err      = ($urandom_range(0, 29) == 0);
      flush    = ($urandom_range(0, 39) == 0) || (m_halt && $urandom_range(0, 7) == 0);
      flush_pc = $urandom;
      rd_en    = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch.md
IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 SHALL have parameters: P_ADDR_WIDTH, default 32, fetch address width; P_DATA_WIDTH, default 32, instruction width; P_DEPTH, default 8, entries in the downstream fifo_sc; P_MAX_OUTST, default 2, maximum granted-but-unanswered requests; P_BOOT_ADDR, default 32'h0000_0000, first fetch address.
REQ-002 SHALL have these ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_fetch_en  in  1  permits fetching.
- i_flush  in  1  redirect strobe.
- i_flush_pc  in  P_ADDR_WIDTH  redirect target.
- o_mem_req  out  1  request valid.
- o_mem_addr  out  P_ADDR_WIDTH  request address.
- i_mem_gnt  in  1  request accepted.
- i_mem_rvalid  in  1  response valid.
- i_mem_rdata  in  P_DATA_WIDTH  response data.
- i_mem_err  in  1  response error, qualified by i_mem_rvalid.
- o_fifo_wr_en  out  1  push into fifo_sc.
- o_fifo_data  out  P_ADDR_WIDTH+P_DATA_WIDTH+2  pushed word {epoch, err, pc, instr}.
- i_fifo_rd_en  in  1  copy of the consumer's pop strobe.
- o_epoch  out  1  current epoch.
- o_halted  out  1  fetch stopped on error.

Function
REQ-003 SHALL implement states IDLE, FETCH, KILL and HALT.
REQ-004 State transitions SHALL be:
- IDLE->FETCH when i_fetch_en=1.
- FETCH->IDLE when i_fetch_en=0 and no request is outstanding.
- any state->KILL on i_flush when stale requests are outstanding.
- any state->FETCH on i_flush otherwise.
- KILL->FETCH when the stale count reaches 0.
- FETCH->HALT on a current-epoch response with i_mem_err=1.
REQ-005 o_mem_req SHALL assert in FETCH only when i_fetch_en=1, outstanding < P_MAX_OUTST and occupancy+outstanding < P_DEPTH.
REQ-006 o_mem_addr SHALL equal the fetch PC while o_mem_req is asserted.
REQ-007 Once asserted, o_mem_req and o_mem_addr SHALL hold stable until i_mem_gnt; the only exception is i_flush, which withdraws the request.
REQ-008 On o_mem_req and i_mem_gnt, the PC SHALL advance by 4 (modulo 2^P_ADDR_WIDTH, wrap to 0 permitted), outstanding SHALL increment, and the request PC SHALL be queued in an internal P_MAX_OUTST-entry in-order tag queue.
REQ-009 The bus SHALL return responses in order, at least one cycle after grant, exactly one i_mem_rvalid per grant.
REQ-010 A current-epoch response SHALL cause, in the same cycle, o_fifo_wr_en=1 and o_fifo_data={o_epoch, i_mem_err, tag-queue head PC, i_mem_rdata}, and SHALL pop the tag queue and decrement outstanding.
REQ-011 A stale response (granted before the latest flush) SHALL NOT be pushed; it pops the tag queue and decrements the stale count.
REQ-012 On i_flush the block SHALL, next cycle:
- set PC to i_flush_pc with the low 2 bits cleared;
- toggle o_epoch;
- move all outstanding requests, including any granted in the flush cycle, to the stale count;
- clear o_halted.
REQ-013 Occupancy SHALL count +1 per push and -1 per i_fifo_rd_en when occupancy>0; push and pop in the same cycle SHALL leave it unchanged. Occupancy SHALL NOT be reset by flush.
REQ-014 A response arriving together with i_flush SHALL be treated as current-epoch.
REQ-015 In KILL, o_mem_req SHALL be 0.
REQ-016 In HALT, o_mem_req SHALL be 0 and o_halted SHALL be 1; remaining responses are still pushed. Only i_flush exits HALT.
REQ-017 o_fifo_wr_en SHALL never assert when occupancy=P_DEPTH.

Reset
REQ-018 While i_rstn=0, asynchronously: state=IDLE, PC=P_BOOT_ADDR, o_epoch=0, outstanding=0, stale count=0, occupancy=0, tag queue empty, o_mem_req=0, o_fifo_wr_en=0, o_halted=0, o_mem_addr=P_BOOT_ADDR, o_fifo_data=0.
REQ-019 Reset asserted mid-operation SHALL discard all in-flight state; responses arriving after reset release with no outstanding request SHALL be ignored.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Reset release, i_fetch_en=1, gnt every cycle, rvalid 1 cycle later -> pushes PC 0x0,0x4,0x8... with instr=rdata, epoch 0, err 0.
- No i_fifo_rd_en, P_DEPTH=8 -> exactly 8 grants, o_mem_req stays 0 thereafter; one pop -> one further request.
- Two requests granted, then i_flush with i_flush_pc=0x103 -> both responses not pushed; next request address 0x100 after KILL; pushed epoch=1.
- i_mem_gnt held 0 for 5 cycles -> o_mem_addr stable; PC 0xFFFF_FFFC granted -> next address 0x0.
- Response with i_mem_err=1 -> pushed with err=1, o_halted=1, o_mem_req=0 until i_flush.
- i_rstn pulsed low with 2 outstanding -> all outputs at reset values within the reset cycle; fetch restarts at P_BOOT_ADDR.
